// File: rtl/tx_frame_source_pkg.sv
// Shared constants, FSM state type and PRBS step function for the framed symbol source.
package tx_frame_source_pkg;

  localparam int unsigned PRBS_WIDTH = 22;
  localparam int unsigned PRBS_TAP_A = 21;
  localparam int unsigned PRBS_TAP_B = 20;
  localparam int unsigned SYM_IDX_W  = 11;

  localparam logic [1:0] PRE_SYM_HI = 2'b11;
  localparam logic [1:0] PRE_SYM_LO = 2'b00;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPreamble = 2'd1,
    StPayload  = 2'd2
  } state_e;

  // One Fibonacci step of x^22 + x^21 + 1; the output bit is the MSB before shifting.
  function automatic logic [PRBS_WIDTH-1:0] prbs_step(input logic [PRBS_WIDTH-1:0] s);
    return {s[PRBS_WIDTH-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/tx_frame_source_prbs_lfsr_2step.sv
// 22-bit Fibonacci LFSR producing one 2-bit symbol (two steps) per advance; reloadable seed.
module tx_frame_source_prbs_lfsr_2step
  import tx_frame_source_pkg::*;
#(
  parameter logic [PRBS_WIDTH-1:0] SEED = 22'h3FFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [1:0] sym
);

  logic [PRBS_WIDTH-1:0] state_q;
  logic [PRBS_WIDTH-1:0] step1;
  logic [PRBS_WIDTH-1:0] step2;

  always_comb begin
    step1 = prbs_step(state_q);
    step2 = prbs_step(step1);
    sym   = {state_q[PRBS_WIDTH-1], step1[PRBS_WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= step2;
    end
  end

endmodule

// File: rtl/tx_frame_source.sv
// Framed 2-bit symbol source: alternating preamble then PRBS payload, one symbol per sym_clk_en.
// Optional build macro TX_FRAME_ERR_INJECT_EN adds err_inject (flips tx_data[0] of one payload symbol).
module tx_frame_source
  import tx_frame_source_pkg::*;
#(
  parameter int unsigned           PREAMBLE_LEN = 64,
  parameter int unsigned           PAYLOAD_LEN  = 1024,
  parameter logic [PRBS_WIDTH-1:0] LFSR_SEED    = 22'h3FFFFF,
  parameter logic [1:0]            IDLE_SYM     = 2'b00
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sym_clk_en,
  input  logic                 enable,
`ifdef TX_FRAME_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  output logic [1:0]           tx_data,
  output logic                 frame_start,
  output logic                 in_payload,
  output logic [SYM_IDX_W-1:0] sym_idx
);

  localparam logic [SYM_IDX_W-1:0] PRE_LAST = SYM_IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [SYM_IDX_W-1:0] PAY_LAST = SYM_IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [SYM_IDX_W-1:0] IDX_ONE  = SYM_IDX_W'(1);

  state_e               state_q, state_d;
  logic [1:0]           tx_q, tx_d;
  logic [SYM_IDX_W-1:0] idx_q, idx_d;
  logic                 in_pay_q, in_pay_d;
  logic                 frame_start_q;
  logic                 start_tick;
  logic                 pay_load;
  logic [1:0]           lfsr_sym;
  logic                 inject;

  tx_frame_source_prbs_lfsr_2step #(
    .SEED (LFSR_SEED)
  ) u_prbs (
    .clk     (sys_clk),
    .rst     (reset),
    .load    (start_tick),
    .advance (pay_load),
    .sym     (lfsr_sym)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    idx_d      = idx_q;
    in_pay_d   = in_pay_q;
    start_tick = 1'b0;
    pay_load   = 1'b0;
    if (sym_clk_en) begin
      unique case (state_q)
        StIdle: begin
          tx_d = IDLE_SYM;
          if (enable) start_tick = 1'b1;
        end
        StPreamble: begin
          if (idx_q == PRE_LAST) begin
            state_d  = StPayload;
            idx_d    = '0;
            in_pay_d = 1'b1;
            pay_load = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
            // Current index even -> next one odd -> low symbol.
            tx_d  = idx_q[0] ? PRE_SYM_HI : PRE_SYM_LO;
          end
        end
        StPayload: begin
          if (idx_q == PAY_LAST) begin
            if (enable) begin
              start_tick = 1'b1;
            end else begin
              state_d  = StIdle;
              tx_d     = IDLE_SYM;
              idx_d    = '0;
              in_pay_d = 1'b0;
            end
          end else begin
            idx_d    = idx_q + IDX_ONE;
            pay_load = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (start_tick) begin
      state_d  = StPreamble;
      tx_d     = PRE_SYM_HI;
      idx_d    = '0;
      in_pay_d = 1'b0;
    end
    if (pay_load) tx_d = lfsr_sym ^ {1'b0, inject};
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      tx_q          <= IDLE_SYM;
      idx_q         <= '0;
      in_pay_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_q          <= tx_d;
      idx_q         <= idx_d;
      in_pay_q      <= in_pay_d;
      // Reloaded every cycle so the pulse lasts exactly one sys_clk.
      frame_start_q <= start_tick;
    end
  end

`ifdef TX_FRAME_ERR_INJECT_EN
  logic armed_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= (armed_q & ~pay_load) | err_inject;
    end
  end

  assign inject = armed_q;
`else
  assign inject = 1'b0;
`endif

  assign tx_data     = tx_q;
  assign frame_start = frame_start_q;
  assign in_payload  = in_pay_q;
  assign sym_idx     = idx_q;

endmodule

// File: tb/tb_tx_frame_source.sv
// Scoreboard bench for tx_frame_source: a frame-position model queues the expected outputs per tick.
module tb_tx_frame_source;

  localparam int PRE   = 64;
  localparam int PAY   = 1024;
  localparam int FRAME = PRE + PAY;
  localparam logic [21:0] SEED = 22'h3FFFFF;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_clk_en = 1'b0;
  logic        enable = 1'b0;
`ifdef TX_FRAME_ERR_INJECT_EN
  logic        err_inject = 1'b0;
`endif
  logic [1:0]  tx_data;
  logic        frame_start;
  logic        in_payload;
  logic [10:0] sym_idx;

  tx_frame_source dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sym_clk_en  (sym_clk_en),
    .enable      (enable),
`ifdef TX_FRAME_ERR_INJECT_EN
    .err_inject  (err_inject),
`endif
    .tx_data     (tx_data),
    .frame_start (frame_start),
    .in_payload  (in_payload),
    .sym_idx     (sym_idx)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          tick_cnt = 0;
  logic [15:0] exp_q[$];
  int          fs_ticks[$];
  logic [15:0] e_last = '0;

  // Model state: position within the 1088-symbol frame plus a software LFSR.
  bit          m_active = 0;
  int          m_pos = 0;
  logic [21:0] m_lfsr = SEED;
  bit          m_armed = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack(input logic [1:0] tx, input logic fs, input logic ip,
                                       input int idx);
    return {1'b0, tx, fs, ip, idx[10:0]};
  endfunction

  function automatic logic [15:0] observe();
    return {1'b0, tx_data, frame_start, in_payload, sym_idx};
  endfunction

  task automatic model_step(input logic en);
    logic [15:0] e;
    logic [1:0]  sym;
    if (!m_active || m_pos == FRAME - 1) begin
      if (en) begin
        m_active = 1;
        m_pos    = 0;
        m_lfsr   = SEED;
        e        = pack(2'b11, 1'b1, 1'b0, 0);
      end else begin
        m_active = 0;
        e        = pack(2'b00, 1'b0, 1'b0, 0);
      end
    end else begin
      m_pos++;
      if (m_pos < PRE) begin
        e = pack((m_pos % 2 == 0) ? 2'b11 : 2'b00, 1'b0, 1'b0, m_pos);
      end else begin
        sym[1] = m_lfsr[21];
        m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
        sym[0] = m_lfsr[21];
        m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
        if (m_armed) begin
          sym[0]  = ~sym[0];
          m_armed = 0;
        end
        e = pack(sym, 1'b0, 1'b1, m_pos - PRE);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic do_tick(input logic en, input int gap, input string tag);
    @(negedge sys_clk);
    sym_clk_en = 1'b1;
    enable     = en;
    model_step(en);
    @(posedge sys_clk);
    #1;
    tick_cnt++;
    if (frame_start) fs_ticks.push_back(tick_cnt);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %h", tag, observe());
    end else begin
      e_last = exp_q.pop_front();
      check_eq(tag, observe(), e_last);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge sys_clk);
      sym_clk_en = 1'b0;
      @(posedge sys_clk);
      #1;
      if (g == 0) check_eq({tag, "_hold"}, observe(), e_last & 16'hEFFF);
    end
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sym_clk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("reset_async", observe(), pack(2'b00, 1'b0, 1'b0, 0));
    m_active = 0;
    m_lfsr   = SEED;
    m_armed  = 0;
    exp_q.delete();
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    @(posedge sys_clk);
    #1;
    check_eq("reset_state", observe(), pack(2'b00, 1'b0, 1'b0, 0));
    @(negedge sys_clk);
    reset = 1'b0;

    // Idle with sparse enables.
    for (int i = 0; i < 20; i++) do_tick(1'b0, 3, "idle");
    check_eq("idle_no_fs", 16'(fs_ticks.size()), 16'd0);

    // Continuous frames with sym_clk_en held high.
    fs_ticks.delete();
    tick_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) do_tick(1'b1, 0, "frame");
    check_eq("fs_count", 16'(fs_ticks.size()), 16'd3);
    if (fs_ticks.size() >= 2) begin
      check_eq("fs_spacing", 16'(fs_ticks[1] - fs_ticks[0]), 16'(FRAME));
    end else begin
      check_eq("fs_spacing", 16'(fs_ticks.size()), 16'd2);
    end

    // Enable dropped mid-payload: frame still completes, then idles.
    for (int i = 0; i < 2 * FRAME && !(m_active && m_pos == PRE + 100); i++)
      do_tick(1'b1, $urandom_range(0, 1), "run_to_100");
    for (int i = 0; i < 2 * FRAME && m_active; i++)
      do_tick(1'b0, $urandom_range(0, 1), "drain");
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1, "post_frame_idle");

    // Reset in the middle of the preamble, then restart from preamble 0.
    for (int i = 0; i < 31; i++) do_tick(1'b1, 0, "pre_to_30");
    check_eq("pre_idx30", {5'd0, sym_idx}, 16'd30);
    apply_reset();
    do_tick(1'b0, 0, "after_reset");
    for (int i = 0; i < PRE + 20; i++) do_tick(1'b1, $urandom_range(0, 2), "restart");

`ifdef TX_FRAME_ERR_INJECT_EN
    apply_reset();
    for (int i = 0; i < 10; i++) do_tick(1'b1, 0, "inj_pre");
    @(negedge sys_clk);
    err_inject = 1'b1;
    m_armed    = 1;
    @(negedge sys_clk);
    err_inject = 1'b0;
    for (int i = 0; i < PRE + 10; i++) do_tick(1'b1, 0, "inj_run");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
